// File: rtl/sent_tx_scheduler.sv
// Round-robin launcher for up to four SENT message requesters driving one SENT TX control block.
// Optional completion timeout is compiled in with the SENT_TX_SCHED_TIMEOUT_EN macro.
module sent_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_tx,
    input  logic                    reset_n_tx,
    input  logic                    enable_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [8*NUM_REQ-1:0]    id_i,
    input  logic [16*NUM_REQ-1:0]   data_i,
    input  logic [NUM_REQ-1:0]      format_i,
    input  logic [NUM_REQ-1:0]      config_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic                    busy_o,
    output logic                    timeout_o,
    output logic                    tx_enable_o,
    output logic                    tx_channel_format_o,
    output logic                    tx_config_bit_o,
    output logic [7:0]              tx_id_o,
    output logic [15:0]             tx_data_bit_field_o,
    input  logic                    tx_idle_i,
    output logic [1:0]              state_dbg_o
);

    // req_i is a level request: a slot is served when grant_o pulses for it, and its
    // id/data/format/config are captured on that same edge; afterwards req_i may drop or stay.

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_e;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    if (NUM_REQ != 4 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("sent_tx_scheduler: parameter out of supported range");
    end

    state_e               state_q, state_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 idle_q, idle_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic                 tx_enable_q, tx_enable_d;
    logic                 tx_format_q, tx_format_d;
    logic                 tx_config_q, tx_config_d;
    logic [7:0]           tx_id_q, tx_id_d;
    logic [15:0]          tx_data_q, tx_data_d;
`ifdef SENT_TX_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          to_cnt_q, to_cnt_d;
`endif

    logic                 win_valid;
    logic [1:0]           win_idx;
    logic [1:0]           cand;
    logic                 idle_rise;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_grant_q;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_grant_q + 2'(i);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // idle_q holds tx_idle_i from the previous cycle, so a level already high at launch is not an edge.
    assign idle_rise = tx_idle_i & ~idle_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        idle_d       = tx_idle_i;
        grant_d      = '0;
        done_d       = '0;
        timeout_d    = 1'b0;
        tx_enable_d  = 1'b0;
        tx_format_d  = tx_format_q;
        tx_config_d  = tx_config_q;
        tx_id_d      = tx_id_q;
        tx_data_d    = tx_data_q;
`ifdef SENT_TX_SCHED_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_i && win_valid) begin
                    grant_d[win_idx] = 1'b1;
                    tx_enable_d      = 1'b1;
                    tx_format_d      = format_i[win_idx];
                    tx_config_d      = config_i[win_idx];
                    tx_id_d          = id_i[{win_idx, 3'b000} +: 8];
                    tx_data_d        = data_i[{win_idx, 4'b0000} +: 16];
                    last_grant_d     = win_idx;
                    state_d          = ST_WAIT_DONE;
`ifdef SENT_TX_SCHED_TIMEOUT_EN
                    to_cnt_d         = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (idle_rise) begin
                    done_d[last_grant_q] = 1'b1;
                    gap_cnt_d            = '0;
                    state_d              = ST_GAP;
                end
`ifdef SENT_TX_SCHED_TIMEOUT_EN
                else if (to_cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd3;
            gap_cnt_q    <= '0;
            idle_q       <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            tx_enable_q  <= 1'b0;
            tx_format_q  <= 1'b0;
            tx_config_q  <= 1'b0;
            tx_id_q      <= '0;
            tx_data_q    <= '0;
`ifdef SENT_TX_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            idle_q       <= idle_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            tx_enable_q  <= tx_enable_d;
            tx_format_q  <= tx_format_d;
            tx_config_q  <= tx_config_d;
            tx_id_q      <= tx_id_d;
            tx_data_q    <= tx_data_d;
`ifdef SENT_TX_SCHED_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign grant_o             = grant_q;
    assign done_o              = done_q;
    assign busy_o              = busy_q;
    assign timeout_o           = timeout_q;
    assign tx_enable_o         = tx_enable_q;
    assign tx_channel_format_o = tx_format_q;
    assign tx_config_bit_o     = tx_config_q;
    assign tx_id_o             = tx_id_q;
    assign tx_data_bit_field_o = tx_data_q;
    assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Self-checking bench for sent_tx_scheduler: cycle model of launch/complete/gap plus directed scenarios.
module tb_sent_tx_scheduler;

    localparam int GAP     = 8;
    localparam int TIMEOUT = 100;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] id;
    logic [63:0] data;
    logic [3:0]  fmt;
    logic [3:0]  cfg;
    logic        tx_idle;
    logic [3:0]  grant_o, done_o;
    logic        busy_o, timeout_o, tx_enable_o, tx_fmt_o, tx_cfg_o;
    logic [7:0]  tx_id_o;
    logic [15:0] tx_data_o;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    sent_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_tx(clk), .reset_n_tx(rst_n), .enable_i(enable), .req_i(req),
        .id_i(id), .data_i(data), .format_i(fmt), .config_i(cfg),
        .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .tx_enable_o(tx_enable_o), .tx_channel_format_o(tx_fmt_o),
        .tx_config_bit_o(tx_cfg_o), .tx_id_o(tx_id_o),
        .tx_data_bit_field_o(tx_data_o), .tx_idle_i(tx_idle), .state_dbg_o(state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // behavioural model: a message is in flight until a fresh rise of tx_idle,
    // then GAP quiet cycles elapse before the next launch may happen
    logic [3:0]  e_grant, e_done;
    logic        e_busy, e_to, e_txen, e_fmt, e_cfg;
    logic [7:0]  e_id;
    logic [15:0] e_data;
    int          m_last, m_slot, m_gap_left, m_waited;
    bit          m_inflight, m_prev;
    int          cyc;
    bit          log_en;
    logic [3:0]  obs_q[$];
    int          txen_t[$];
    logic [3:0]  exp_q[$];

    task automatic model_reset();
        e_grant = '0; e_done = '0; e_busy = 0; e_to = 0; e_txen = 0;
        e_fmt = 0; e_cfg = 0; e_id = '0; e_data = '0;
        m_last = 3; m_slot = 0; m_gap_left = 0; m_waited = 0;
        m_inflight = 0; m_prev = 0;
    endtask

    task automatic model_step();
        int s;
        e_grant = '0; e_done = '0; e_to = 0; e_txen = 0;
        if (m_inflight) begin
            m_waited++;
            if (tx_idle && !m_prev) begin
                e_done = 4'b0001 << m_slot;
                m_inflight = 0;
                m_gap_left = GAP;
            end
`ifdef SENT_TX_SCHED_TIMEOUT_EN
            else if (m_waited == TIMEOUT) begin
                e_to = 1;
                m_inflight = 0;
                m_gap_left = GAP;
            end
`endif
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (enable && req != 4'b0000) begin
            for (int off = 1; off <= 4; off++) begin
                s = (m_last + off) % 4;
                if (req[s] && !m_inflight) begin
                    m_inflight = 1;
                    m_slot = s;
                end
            end
            m_last   = m_slot;
            m_waited = 0;
            e_grant  = 4'b0001 << m_slot;
            e_txen   = 1;
            e_fmt    = fmt[m_slot];
            e_cfg    = cfg[m_slot];
            e_id     = id[8*m_slot +: 8];
            e_data   = data[16*m_slot +: 16];
        end
        m_prev = tx_idle;
        e_busy = m_inflight || (m_gap_left > 0);
    endtask

    initial model_reset();

    // compare process: every negedge, outputs must equal the model's prediction
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) model_reset();
        check("grant_o", grant_o, e_grant);
        check("done_o", done_o, e_done);
        check("busy_o", busy_o, e_busy);
        check("timeout_o", timeout_o, e_to);
        check("tx_enable_o", tx_enable_o, e_txen);
        check("tx_format", tx_fmt_o, e_fmt);
        check("tx_config", tx_cfg_o, e_cfg);
        check("tx_id_o", tx_id_o, e_id);
        check("tx_data", tx_data_o, e_data);
        if (log_en && tx_enable_o) begin
            obs_q.push_back(grant_o);
            txen_t.push_back(cyc);
        end
        if (rst_n) model_step();
    end

    // driver tasks
    task automatic wait_for(input int sel, input int budget, input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = tx_enable_o;
                1: hit = (done_o != 4'b0000);
                2: hit = !busy_o;
                default: hit = timeout_o;
            endcase
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL wait_%s actual=not_seen expected=seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; req = '0; enable = 0; tx_idle = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic finish_msg(input logic [3:0] exp_done, input string nm);
        @(posedge clk); #1 tx_idle = 0; req = '0;
        @(posedge clk); #1 tx_idle = 1;
        wait_for(1, 10, nm);
        check(nm, done_o, exp_done);
        wait_for(2, GAP + 5, {nm, "_idle"});
    endtask

    int busy_n, done_n, done_k, grant_n, to_k, txen_k;

    initial begin
        rst_n = 0; enable = 0; req = '0; tx_idle = 1; fmt = '0; cfg = '0;
        id = '0; data = '0; log_en = 0; cyc = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("reset_state", {grant_o, done_o, busy_o, tx_enable_o, tx_id_o, tx_data_o}, '0);
        check("reset_state_dbg", state_dbg, 2'd0);

        // single request on slot 1; tx_idle already high at launch must not complete it
        @(posedge clk); #1;
        id = {8'h44, 8'h33, 8'hA5, 8'h11};
        data = {16'h4444, 16'h3333, 16'h0123, 16'h1111};
        fmt = 4'b0101; cfg = 4'b0110;
        enable = 1; req = 4'b0010;
        @(posedge clk); @(negedge clk);
        check("single_grant", grant_o, 4'b0010);
        check("single_txen", tx_enable_o, 1'b1);
        check("single_id", tx_id_o, 8'hA5);
        check("single_data", tx_data_o, 16'h0123);
        check("single_fmt_cfg", {tx_fmt_o, tx_cfg_o}, 2'b01);
        @(posedge clk); #1 req = '0; id = '1; data = '1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("hold_id", tx_id_o, 8'hA5);
        check("hold_data", tx_data_o, 16'h0123);
        check("no_done_high_at_launch", done_o, 4'b0000);
        finish_msg(4'b0010, "single_done");

        // all four requesting: round-robin from slot 0
        do_reset();
        id = {8'h44, 8'h33, 8'h22, 8'h11};
        data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        obs_q.delete(); txen_t.delete();
        log_en = 1; enable = 1; req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_for(0, 40, "rr_launch");
            @(posedge clk); #1 tx_idle = 0;
            @(posedge clk); @(posedge clk); #1 tx_idle = 1;
            if (n == 4) req = '0;
        end
        wait_for(2, 40, "rr_idle");
        log_en = 0;
        check("rr_count", obs_q.size(), 5);
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check("rr_order", obs_q.pop_front(), exp_q.pop_front());
        for (int n = 1; n < txen_t.size(); n++)
            check("rr_spacing_ge_gap", (txen_t[n] - txen_t[n-1]) >= GAP, 1'b1);

        // slot 2 completes 40 cycles after launch
        @(posedge clk); #1 req = 4'b0100; tx_idle = 0;
        wait_for(0, 10, "slot2_launch");
        check("slot2_grant", grant_o, 4'b0100);
        busy_n = busy_o; done_n = 0; done_k = -1;
        for (int k = 1; k < 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) req = '0;
            tx_idle = (k >= 39);
            @(negedge clk);
            busy_n += busy_o;
            if (done_o != 4'b0000) begin
                done_n++; done_k = k;
                check("slot2_done", done_o, 4'b0100);
            end
        end
        check("slot2_done_count", done_n, 1);
        check("slot2_done_cycle", done_k, 40);
        check("slot2_busy_cycles", busy_n, 40 + GAP);

        // enable dropped while in flight; slot 0 request withdrawn meanwhile
        @(posedge clk); #1 req = 4'b1011; tx_idle = 1;
        wait_for(0, 10, "en_launch");
        check("en_grant", grant_o, 4'b1000);
        @(posedge clk); #1 enable = 0; req = 4'b1010; tx_idle = 0;
        @(posedge clk); #1 tx_idle = 1;
        wait_for(1, 10, "en_done");
        check("en_done", done_o, 4'b1000);
        grant_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (grant_o != 4'b0000) grant_n++;
        end
        check("en_blocked_grants", grant_n, 0);
        @(posedge clk); #1 enable = 1;
        wait_for(0, 5, "en_relaunch");
        check("en_skip_dropped", grant_o, 4'b0010);
        finish_msg(4'b0010, "en_done2");

        // reset in the middle of a message
        @(posedge clk); #1 req = 4'b0001; tx_idle = 0;
        wait_for(0, 10, "rst_launch");
        check("rst_pre_fmt", tx_fmt_o, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 0;
        #1 check("rst_immediate", {grant_o, done_o, busy_o, timeout_o, tx_enable_o,
                                   tx_fmt_o, tx_cfg_o, tx_id_o, tx_data_o}, '0);
        @(posedge clk); #1 tx_idle = 1; req = 4'b1000;
        @(posedge clk); #1 rst_n = 1;
        wait_for(0, 5, "rst_relaunch");
        check("rst_relaunch_grant", grant_o, 4'b1000);
        done_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o != 4'b0000) done_n++;
        end
        check("rst_no_stale_done", done_n, 0);
        finish_msg(4'b1000, "rst_done");

`ifdef SENT_TX_SCHED_TIMEOUT_EN
        // tx_idle never rises: timeout at 100 cycles, relaunch after the gap
        @(posedge clk); #1 req = 4'b0100; tx_idle = 0;
        wait_for(0, 10, "to_launch");
        to_k = -1; txen_k = -1; done_n = 0;
        for (int k = 1; k <= 115; k++) begin
            @(negedge clk);
            if (timeout_o && to_k < 0) to_k = k;
            if (tx_enable_o && txen_k < 0) txen_k = k;
            if (done_o != 4'b0000) done_n++;
        end
        check("to_cycle", to_k, 100);
        check("to_no_done", done_n, 0);
        check("to_relaunch_cycle", txen_k, 100 + GAP + 1);
        finish_msg(4'b0100, "to_done");
`else
        @(posedge clk); #1 req = 4'b0100; tx_idle = 0;
        wait_for(0, 10, "nto_launch");
        to_k = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (timeout_o) to_k++;
        end
        check("nto_no_timeout", to_k, 0);
        check("nto_still_busy", busy_o, 1'b1);
        finish_msg(4'b0100, "nto_done");
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
